// File: rtl/output_buffer_if.sv
// Row-capture and host-read bundle between the accelerator datapath, the
// result buffer and the host.
interface output_buffer_if #(
    parameter int DEPTH = 16
);
    logic                     output_valid;
    logic [63:0]              output_values;
    logic                     overflow;
    logic                     rd_en;
    logic [63:0]              rd_data;
    logic                     rd_ovf;
    logic                     rd_last;
    logic                     rd_valid;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     matrix_ready;
    logic                     drop_err;
    logic                     under_err;

    modport slave (
        input  output_valid, output_values, overflow, rd_en,
        output rd_data, rd_ovf, rd_last, rd_valid, count, empty, full,
        matrix_ready, drop_err, under_err
    );

    modport master (
        output output_valid, output_values, overflow, rd_en,
        input  rd_data, rd_ovf, rd_last, rd_valid, count, empty, full,
        matrix_ready, drop_err, under_err
    );
endinterface

// File: rtl/output_buffer.sv
// Circular result FIFO: captures activated rows tagged with overflow and
// matrix-end markers, serves them to the host with a one-cycle registered read.
module output_buffer #(
    parameter int DEPTH = 16,
    parameter int ROWS  = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           clear,
    output_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [RW-1:0] IDX_LAST = RW'(ROWS - 1);

    logic [65:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d, mcount_q, mcount_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic          drop_q, drop_d, under_q, under_d;
    logic          rd_valid_q, rd_valid_d, rd_ovf_q, rd_ovf_d, rd_last_q, rd_last_d;
    logic [63:0]   rd_data_q, rd_data_d;
    logic          empty_s, full_s, rd_acc_s, wr_acc_s, wr_last_s;
    logic [65:0]   rd_entry_s;

    // Occupancy decodes and accept qualifiers; a read on empty never frees a slot.
    always_comb begin
        empty_s    = (count_q == {CW{1'b0}});
        full_s     = (count_q == CNT_FULL);
        rd_acc_s   = bus.rd_en && !empty_s;
        wr_acc_s   = bus.output_valid && (!full_s || rd_acc_s);
        wr_last_s  = (row_idx_q == IDX_LAST);
        rd_entry_s = mem_q[rp_q];
    end

    // Next-state for pointers, counters, read register and sticky flags.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        mcount_d   = mcount_q;
        row_idx_d  = row_idx_q;
        rd_valid_d = rd_acc_s;
        rd_data_d  = rd_data_q;
        rd_ovf_d   = rd_ovf_q;
        rd_last_d  = rd_last_q;
        drop_d     = drop_q | (bus.output_valid & ~wr_acc_s);
        under_d    = under_q | (bus.rd_en & empty_s);

        if (rd_acc_s) begin
            rd_data_d = rd_entry_s[63:0];
            rd_ovf_d  = rd_entry_s[64];
            rd_last_d = rd_entry_s[65];
            rp_d      = rp_q + AW'(1);
        end else begin
            rp_d      = rp_q;
        end

        if (wr_acc_s) begin
            wp_d      = wp_q + AW'(1);
            row_idx_d = wr_last_s ? {RW{1'b0}} : row_idx_q + RW'(1);
        end else begin
            wp_d      = wp_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({wr_acc_s & wr_last_s, rd_acc_s & rd_entry_s[65]})
            2'b10:   mcount_d = mcount_q + CW'(1);
            2'b01:   mcount_d = mcount_q - CW'(1);
            default: mcount_d = mcount_q;
        endcase

        if (clear) begin
            wp_d       = {AW{1'b0}};
            rp_d       = {AW{1'b0}};
            count_d    = {CW{1'b0}};
            mcount_d   = {CW{1'b0}};
            row_idx_d  = {RW{1'b0}};
            rd_valid_d = 1'b0;
            rd_data_d  = 64'd0;
            rd_ovf_d   = 1'b0;
            rd_last_d  = 1'b0;
            drop_d     = 1'b0;
            under_d    = 1'b0;
        end else begin
            wp_d       = wp_d;
        end
    end

    // State register; n_rst is a synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wp_q       <= {AW{1'b0}};
            rp_q       <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            mcount_q   <= {CW{1'b0}};
            row_idx_q  <= {RW{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= 64'd0;
            rd_ovf_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            drop_q     <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            mcount_q   <= mcount_d;
            row_idx_q  <= row_idx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
            rd_last_q  <= rd_last_d;
            drop_q     <= drop_d;
            under_q    <= under_d;
        end
    end

    // Row storage; contents are left untouched by reset and clear.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !n_rst && !clear) begin
            mem_q[wp_q] <= {wr_last_s, bus.overflow, bus.output_values};
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_ovf       = rd_ovf_q;
    assign bus.rd_last      = rd_last_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_s;
    assign bus.full         = full_s;
    assign bus.matrix_ready = (mcount_q != {CW{1'b0}});
    assign bus.drop_err     = drop_q;
    assign bus.under_err    = under_q;
endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_output_buffer;
    localparam int DEPTH = 16;
    localparam int ROWS  = 8;

    logic clk;
    logic n_rst;
    logic clear;

    output_buffer_if #(.DEPTH(DEPTH)) bus ();

    output_buffer #(.DEPTH(DEPTH), .ROWS(ROWS)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [65:0] mq[$];
    int          m_idx;
    logic        m_drop, m_under, m_valid, m_ovf, m_last;
    logic [63:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic clr, input logic ov,
                        input logic [63:0] val, input logic of, input logic rd);
        logic [65:0] e;
        logic        racc, wacc, lst;
        int          mc;
        n_rst             = rst;
        clear             = clr;
        bus.output_valid  = ov;
        bus.output_values = val;
        bus.overflow      = of;
        bus.rd_en         = rd;
        if (rst || clr) begin
            mq.delete();
            m_idx = 0; m_drop = 1'b0; m_under = 1'b0; m_valid = 1'b0;
            m_data = 64'd0; m_ovf = 1'b0; m_last = 1'b0;
        end else begin
            racc = rd && (mq.size() != 0);
            wacc = ov && ((mq.size() != DEPTH) || racc);
            m_valid = racc;
            if (racc) begin
                e = mq.pop_front();
                m_data = e[63:0]; m_ovf = e[64]; m_last = e[65];
            end
            if (rd && !racc) m_under = 1'b1;
            if (ov && !wacc) m_drop = 1'b1;
            if (wacc) begin
                lst = (m_idx == ROWS - 1);
                mq.push_back({lst, of, val});
                m_idx = (m_idx + 1) % ROWS;
            end
        end
        @(posedge clk);
        #1;
        mc = 0;
        foreach (mq[i]) if (mq[i][65]) mc++;
        chk("count",        64'(bus.count),        64'(mq.size()));
        chk("empty",        64'(bus.empty),        64'(mq.size() == 0));
        chk("full",         64'(bus.full),         64'(mq.size() == DEPTH));
        chk("matrix_ready", 64'(bus.matrix_ready), 64'(mc != 0));
        chk("rd_valid",     64'(bus.rd_valid),     64'(m_valid));
        chk("rd_data",      bus.rd_data,           m_data);
        chk("rd_ovf",       64'(bus.rd_ovf),       64'(m_ovf));
        chk("rd_last",      64'(bus.rd_last),      64'(m_last));
        chk("drop_err",     64'(bus.drop_err),     64'(m_drop));
        chk("under_err",    64'(bus.under_err),    64'(m_under));
    endtask

    task automatic wr(input logic [63:0] val, input logic of);
        step(1'b0, 1'b0, 1'b1, val, of, 1'b0);
    endtask

    task automatic rdc();
        step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [63:0] rv;
        // reset
        step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk("reset_empty", 64'(bus.empty), 64'd1);

        // ordering and matrix tracking: rows 0x01.. through 0x08.., overflow on row 3
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            wr({8{b}}, i == 3);
        end
        chk("matrix_ready_after8", 64'(bus.matrix_ready), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            rdc();
            b = 8'(i);
            chk("order_data", bus.rd_data, {8{b}});
            chk("order_ovf",  64'(bus.rd_ovf),  64'(i == 3));
            chk("order_last", 64'(bus.rd_last), 64'(i == 8));
        end
        chk("matrix_ready_drained", 64'(bus.matrix_ready), 64'd0);
        idle();

        // full / drop: 17 writes, row 17 discarded
        step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) wr(64'(i) << 8, 1'b0);
        chk("full_flag", 64'(bus.full), 64'd1);
        chk("drop_set",  64'(bus.drop_err), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            rdc();
            chk("full_order", bus.rd_data, 64'(i) << 8);
        end
        idle();

        // full with simultaneous read: write accepted, no drop
        step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) wr({$urandom, $urandom}, 1'($urandom));
        step(1'b0, 1'b0, 1'b1, 64'hA5A5_0000_1234_5678, 1'b1, 1'b1);
        chk("full_rw_count", 64'(bus.count), 64'd16);
        chk("full_rw_drop",  64'(bus.drop_err), 64'd0);
        for (int i = 0; i < DEPTH + 1; i++) rdc();

        // empty read with simultaneous write
        step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1);
        chk("empty_rd_under", 64'(bus.under_err), 64'd1);
        chk("empty_rd_count", 64'(bus.count), 64'd1);
        rdc();
        chk("empty_rd_data", bus.rd_data, 64'hDEAD_BEEF_0000_0000);

        // wrap: 40 interleaved writes/reads, then clear with three rows held
        step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) wr({$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 3) != 0));
        while (mq.size() > 0) rdc();
        for (int i = 0; i < 3; i++) wr({$urandom, $urandom}, 1'b1);
        step(1'b0, 1'b1, 1'b1, 64'd7, 1'b0, 1'b1);
        chk("clear_count", 64'(bus.count), 64'd0);

        // reset mid-stream with five rows held
        for (int i = 0; i < 5; i++) wr({$urandom, $urandom}, 1'b0);
        step(1'b1, 1'b0, 1'b1, 64'd9, 1'b1, 1'b1);
        chk("rst_count", 64'(bus.count), 64'd0);

        // random traffic with rare reset/clear
        for (int i = 0; i < 400; i++) begin
            rv = {$urandom, $urandom};
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) != 0), rv, 1'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
# output_buffer

Result buffer directly downstream of the accelerator datapath (systolic array → bias adder → activation). It captures each 64-bit activated row on `output_valid` into a circular FIFO, tags each row with the datapath overflow flag, and tracks 8-row matrix boundaries. It serves rows to the host read interface with a one-cycle registered read. Full-buffer drops and empty-buffer reads are reported through sticky error flags.

## Interface
Parameters:
- DEPTH, 16, number of 64-bit row entries; power of two, ≥ 8
- ROWS, 8, rows per result matrix (matrix-boundary counter modulus)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- n_rst  input  1  reset, synchronous, active-high (1 = reset), despite the name
- clear  input  1  soft clear; empties FIFO and clears flags (same effect as reset)
- output_valid  input  1  activated row present this cycle
- output_values  input  64  activated row, 8 lanes × 8 bits (lane i = bits [8i+7:8i])
- overflow  input  1  datapath overflow associated with this row
- rd_en  input  1  host read request
- rd_data  output  64  row popped by the previous cycle's accepted read
- rd_ovf  output  1  overflow tag of rd_data
- rd_last  output  1  rd_data is the final row (index ROWS-1) of a matrix
- rd_valid  output  1  rd_data/rd_ovf/rd_last valid this cycle
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- matrix_ready  output  1  at least one complete ROWS-row matrix stored
- drop_err  output  1  sticky: a row arrived while full and was discarded
- under_err  output  1  sticky: rd_en asserted while empty

## Operation
- Storage: DEPTH entries of {last, ovf, data[63:0]}; write pointer wp, read pointer rp, both wrap DEPTH-1 → 0; count tracked explicitly.
- Write accept = output_valid && (!full || read accept same cycle). Accepted row is stored at wp; wp++; row_idx++ (mod ROWS); last bit = (row_idx == ROWS-1) before increment.
- Write while full and no read accept: row discarded; drop_err ← 1; wp, count, row_idx unchanged.
- Read accept = rd_en && !empty. Entry at rp is latched into rd_data/rd_ovf/rd_last; rp++. rd_en while empty: no pop, under_err ← 1, rd_valid 0 next cycle.
- count: +1 on write-only accept, −1 on read-only accept, unchanged on both or neither.
- Simultaneous read and write while empty: read is not accepted (empty wins); write is accepted.
- Matrix tracking: mcount = number of stored entries with last = 1; +1 when a last row is written, −1 when a last row is read. matrix_ready = (mcount != 0).
- Priority: n_rst > clear > normal operation. Reset/clear: wp = rp = 0, count = 0, row_idx = 0, mcount = 0, drop_err = under_err = 0, rd_valid = 0, rd_data = 0, rd_ovf = 0, rd_last = 0. Memory contents need not be cleared. Inputs in the reset/clear cycle are ignored.
- rd_data/rd_ovf/rd_last hold their last value when rd_valid = 0.

## Timing
- Write-to-visible: row accepted at edge N; count/empty/full reflect it after edge N; earliest read accept in cycle N+1; data on rd_data in cycle N+2.
- Read latency 1: rd_en accepted in cycle N → rd_valid = 1 with data in cycle N+1 only (single-cycle pulse per accept); back-to-back reads give back-to-back rd_valid.
- full/empty/count/matrix_ready are registered-state decodes (no combinational path from inputs).
- Sticky flags set on the edge after the offending cycle and stay set until reset or clear.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset: drive n_rst = 1 mid-stream with count = 5 → next cycle count = 0, empty = 1, rd_valid = 0, rd_data = 0, all flags 0.
- Ordering/matrix: write rows 0x0101…01 through 0x0808…08 (8 rows, overflow = 0 except row 3) → matrix_ready = 1 after 8th write; 8 reads return the rows in order, rd_ovf = 1 only on row 3, rd_last = 1 only on row 8, matrix_ready = 0 after it is read.
- Full/drop: DEPTH = 16, write 17 rows without reads → full = 1, count = 16, drop_err = 1; reads return rows 1..16, row 17 absent.
- Full with simultaneous read: at full, assert output_valid and rd_en same cycle → write accepted, count stays 16, drop_err stays 0.
- Empty read: rd_en on empty → rd_valid stays 0, under_err = 1; simultaneous write 0xDEADBEEF00000000 is stored, count = 1.
- Wrap/clear: 40 interleaved writes/reads crossing pointer wrap twice → data order preserved; then clear with count = 3 → count = 0, flags cleared.
